shift_pattern_checker: RTL and testbench
========================================

// Module: shift_pattern_checker
// PURPOSE
//   Downstream monitor for the shift-pattern generator's 3-bit LED output.
//   - Sits beside the LED pins and consumes the same pattern vector.
//   - Confirms the pattern is a one-step rotation sequence starting at first_value.
//   - Reports lock, a saturating error count and a sticky stall flag.
//   - Used on-board for ILA and LED self-test of the pattern datapath.
// PARAMETERS
//   WIDTH        3     pattern width in bits (>=2)
//   ROT_LEFT     1     1: expected next = {p[W-2:0],p[W-1]}; 0: {p[0],p[W-1:1]}
//   LOCK_COUNT   4     consecutive correct steps needed for lock (>=1)
//   TIMEOUT_CYC  2**24 clk cycles without a pattern change before stall (>=2)
//   ERR_W        16    width of err_cnt
// PORTS
//   clk          in   1      system clock (differential input after IBUFDS)
//   rst          in   1      synchronous, active-high reset
//   first_value  in   WIDTH  seed pattern, captured while rst=1
//   pat_i        in   WIDTH  pattern under test, synchronous to clk
//   locked       out  1      1 while state==LOCKED
//   state_o      out  2      00 SEEK, 01 TRACK, 10 LOCKED, 11 BADSEED
//   step_ok      out  1      1-cycle pulse: correct step accepted (TRACK/LOCKED)
//   err_cnt      out  ERR_W  mismatches seen in LOCKED; saturates at all-ones
//   stall        out  1      sticky: timeout hit in TRACK/LOCKED; cleared only by rst
// BEHAVIOUR
//   Reset (rst=1 sampled on a clk edge)
//   - seed_q<=first_value; prev_q<=0; state<=SEEK.
//   - All outputs, match_cnt and to_cnt go to 0.
//   - first_value is ignored while rst=0.
//   Events and latency
//   - Event = pat_i != prev_q; prev_q<=pat_i every cycle.
//   - All outputs are registered: response is 1 clk after the pat_i change.
//   - rot(x) applies ROT_LEFT rotation.
//   BADSEED
//   - Entered on the first cycle after reset if seed_q is all-0 or all-1.
//   - Absorbing until rst; locked=0; no counting.
//   SEEK
//   - If pat_i==seed_q: ->TRACK, exp_q<=rot(seed_q), match_cnt<=0, to_cnt<=0.
//   - No timeout counting in SEEK.
//   TRACK, on event
//   - pat_i==exp_q: step_ok=1; exp_q<=rot(pat_i); match_cnt++.
//   - If match_cnt was LOCK_COUNT-1: ->LOCKED.
//   - Mismatch: ->SEEK. err_cnt is unchanged.
//   LOCKED, on event
//   - Match: step_ok=1; exp_q<=rot(pat_i).
//   - Mismatch: err_cnt+=1 (saturating); ->SEEK; locked drops next cycle.
//   Timeout
//   - to_cnt increments each non-event cycle in TRACK/LOCKED and clears on an event.
//   - At to_cnt==TIMEOUT_CYC-1: stall<=1, ->SEEK.
//   Simultaneous conditions
//   - Event and timeout in the same cycle: the event wins.
//   - rst has priority over everything.
//   Mid-operation
//   - Reset mid-sequence returns to SEEK with the newly captured seed.
//   - A seed that reappears mid-TRACK is treated as an ordinary step.
//   Width rules
//   - match_cnt is clog2(LOCK_COUNT+1) bits; to_cnt is clog2(TIMEOUT_CYC) bits.
//   - All compares are unsigned.
// STRUCTURE
//   - Package shift_pattern_pkg: state enum (SEEK/TRACK/LOCKED/BADSEED) and a
//     rot() function, both shared with the generator's testbench model.
//   - One sub-module, pattern_timeout_ctr: to_cnt plus terminal flag, with clear/enable.
//   - The FSM and error counter live in this module.
// TESTING (WIDTH=3, ROT_LEFT=1, LOCK_COUNT=4, TIMEOUT_CYC=16)
//   1. Seed 110; pat 110,101,011,110,101, each held 3 clk.
//      -> TRACK after 110; step_ok x4; locked=1 one clk after the 4th step; err_cnt=0.
//   2. While locked, drive 111 instead of 011.
//      -> err_cnt=1, state SEEK, locked=0 next clk.
//      -> Re-sync from 110 relocks after 4 steps.
//   3. While locked, hold pat constant for 16 clk.
//      -> stall=1, state SEEK.
//      -> stall stays 1 after a later relock until rst.
//   4. Seed 000 (repeat with 111).
//      -> state_o=11, locked=0, err_cnt=0 for 100 clk of random pat.
//   5. Force err_cnt to 16'hFFFE, then inject 3 mismatches while locked.
//      -> err_cnt saturates at 16'hFFFF.
//   6. Pulse rst in TRACK with first_value=011.
//      -> outputs 0 next clk; locks on 011,110,101,011,110.

Source files
------------

// File: rtl/shift_pattern_pkg.sv
// Shared definitions for the shift-pattern checker and the generator's
// bench model.
//   state_t : checker FSM state, encoded exactly as driven on state_o
//   rot()   : one-step rotation of a pattern of run-time width
package shift_pattern_pkg;

    typedef enum logic [1:0] {
        SEEK    = 2'b00,
        TRACK   = 2'b01,
        LOCKED  = 2'b10,
        BADSEED = 2'b11
    } state_t;

    localparam int ROT_MAX_W = 32;
    typedef logic [ROT_MAX_W-1:0] rot_vec_t;

    // Rotate the low 'width' bits of p by one place. Bits above 'width'
    // must be zero on entry and are zero on return.
    function automatic rot_vec_t rot(input rot_vec_t p, input int unsigned width,
                                     input bit left);
        rot_vec_t mask;
        rot_vec_t r;
        // width==ROT_MAX_W wraps the shift to zero, giving an all-ones mask
        mask = (rot_vec_t'(1) << width) - rot_vec_t'(1);
        if (left) begin
            r = (p << 1) | (p >> (width - 1));
        end else begin
            r = (p >> 1) | (p << (width - 1));
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/pattern_timeout_ctr.sv
// Idle-cycle counter for the shift-pattern checker.
//   clk      in  : system clock
//   rst      in  : synchronous active-high reset, count -> 0
//   clear    in  : force count to 0 (wins over enable)
//   enable   in  : count one idle cycle
//   terminal out : count has reached TIMEOUT_CYC-1
module pattern_timeout_ctr
    import shift_pattern_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] to_cnt;

    assign terminal = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Restart after the terminal count so a non-power-of-two limit never
    // leaves the counter beyond its range.
    always_ff @(posedge clk) begin
        if (rst || clear || (enable && terminal)) begin
            to_cnt <= '0;
        end else if (enable) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_pattern_checker.sv
// Monitor for the shift-pattern generator's LED vector: confirms the pattern
// walks a one-step rotation sequence from the seed, reports lock, counts
// mismatches seen while locked and flags a stalled pattern.
//   clk         in  : system clock
//   rst         in  : synchronous active-high reset, captures first_value
//   first_value in  : seed pattern, sampled only while rst=1
//   pat_i       in  : pattern under test
//   locked      out : state is LOCKED
//   state_o     out : 00 SEEK, 01 TRACK, 10 LOCKED, 11 BADSEED
//   step_ok     out : one-cycle pulse per accepted step in TRACK/LOCKED
//   err_cnt     out : saturating count of mismatches seen in LOCKED
//   stall       out : sticky timeout flag, cleared only by rst
module shift_pattern_checker
    import shift_pattern_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int ROT_LEFT    = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT_CYC = 2**24,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] first_value,
    input  logic [WIDTH-1:0] pat_i,
    output logic             locked,
    output logic [1:0]       state_o,
    output logic             step_ok,
    output logic [ERR_W-1:0] err_cnt,
    output logic             stall
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] exp_q;
    logic [MC_W-1:0]  match_cnt;

    logic event_hit;
    logic tracking;
    logic seed_bad;
    logic exp_match;
    logic to_terminal;
    logic seek_hit;
    logic step_ok_d;
    logic err_inc;
    logic stall_set;

    assign event_hit = (pat_i != prev_q);
    assign tracking  = (state == TRACK) || (state == LOCKED);
    assign seed_bad  = (seed_q == '0) || (seed_q == '1);
    assign exp_match = (pat_i == exp_q);

    assign locked  = (state == LOCKED);
    assign state_o = state;

    pattern_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (!tracking || event_hit),
        .enable   (tracking && !event_hit),
        .terminal (to_terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    // A pattern change always takes precedence over the idle timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            SEEK: begin
                if (seed_bad) begin
                    state_next = BADSEED;
                end else if (pat_i == seed_q) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (event_hit) begin
                    if (!exp_match) begin
                        state_next = SEEK;
                    end else if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                        state_next = LOCKED;
                    end
                end else if (to_terminal) begin
                    state_next = SEEK;
                end
            end
            LOCKED: begin
                if (event_hit) begin
                    if (!exp_match) begin
                        state_next = SEEK;
                    end
                end else if (to_terminal) begin
                    state_next = SEEK;
                end
            end
            BADSEED: state_next = BADSEED;
            default: state_next = SEEK;
        endcase
    end

    always_comb begin
        seek_hit  = (state == SEEK) && !seed_bad && (pat_i == seed_q);
        step_ok_d = tracking && event_hit && exp_match;
        err_inc   = (state == LOCKED) && event_hit && !exp_match;
        stall_set = tracking && !event_hit && to_terminal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q    <= first_value;
            prev_q    <= '0;
            exp_q     <= '0;
            match_cnt <= '0;
            step_ok   <= 1'b0;
            err_cnt   <= '0;
            stall     <= 1'b0;
        end else begin
            prev_q  <= pat_i;
            step_ok <= step_ok_d;
            if (seek_hit) begin
                exp_q     <= WIDTH'(rot(rot_vec_t'(seed_q), WIDTH, ROT_LEFT != 0));
                match_cnt <= '0;
            end else if (step_ok_d) begin
                exp_q <= WIDTH'(rot(rot_vec_t'(pat_i), WIDTH, ROT_LEFT != 0));
                if (state == TRACK) begin
                    match_cnt <= match_cnt + MC_W'(1);
                end
            end
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (stall_set) begin
                stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_pattern_checker.sv
// Bench for shift_pattern_checker (WIDTH=3, rotate left, LOCK_COUNT=4,
// TIMEOUT_CYC=16). A second instance with a 2-bit error counter shares all
// stimulus so counter saturation is reachable in a short run.
module tb_shift_pattern_checker;

    localparam logic [1:0] S_SEEK = 2'b00;
    localparam logic [1:0] S_TRK  = 2'b01;
    localparam logic [1:0] S_LCK  = 2'b10;
    localparam logic [1:0] S_BAD  = 2'b11;

    logic        clk;
    logic        rst;
    logic [2:0]  first_value;
    logic [2:0]  pat;
    logic        locked;
    logic [1:0]  state_o;
    logic        step_ok;
    logic [15:0] err_cnt;
    logic        stall;
    logic        locked_s;
    logic [1:0]  state_s;
    logic        step_ok_s;
    logic [1:0]  err_cnt_s;
    logic        stall_s;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        rst;
        logic [2:0]  fv;
        logic [2:0]  pat;
        logic [1:0]  st;
        logic        sok;
        logic [15:0] err;
        logic        stl;
    } vec_t;

    typedef struct packed {
        logic [1:0]  st;
        logic        sok;
        logic [15:0] err;
        logic        stl;
        logic [31:0] tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    shift_pattern_checker #(
        .WIDTH(3), .ROT_LEFT(1), .LOCK_COUNT(4), .TIMEOUT_CYC(16), .ERR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .first_value(first_value), .pat_i(pat),
        .locked(locked), .state_o(state_o), .step_ok(step_ok),
        .err_cnt(err_cnt), .stall(stall)
    );

    shift_pattern_checker #(
        .WIDTH(3), .ROT_LEFT(1), .LOCK_COUNT(4), .TIMEOUT_CYC(16), .ERR_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .first_value(first_value), .pat_i(pat),
        .locked(locked_s), .state_o(state_s), .step_ok(step_ok_s),
        .err_cnt(err_cnt_s), .stall(stall_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic void add(input logic r, input logic [2:0] fv, input logic [2:0] p,
                                input logic [1:0] st, input logic sok,
                                input logic [15:0] err, input logic stl);
        vec_t v;
        v.rst = r; v.fv = fv; v.pat = p; v.st = st; v.sok = sok; v.err = err; v.stl = stl;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int tag, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, tag, act, req);
        end
    endtask

    task automatic apply(input logic r, input logic [2:0] fv, input logic [2:0] p,
                         input logic [1:0] st, input logic sok, input logic [15:0] err,
                         input logic stl, input int tag);
        exp_t e;
        logic [15:0] err_sat;
        @(negedge clk);
        rst = r;
        first_value = fv;
        pat = p;
        e.st = st; e.sok = sok; e.err = err; e.stl = stl; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard[%0d]: got empty queue, expected one entry", tag);
        end else begin
            e = sb.pop_front();
            err_sat = (e.err > 16'd3) ? 16'd3 : e.err;
            chk("state",    int'(e.tag), 16'(state_o),   16'(e.st));
            chk("locked",   int'(e.tag), 16'(locked),    16'(e.st == S_LCK));
            chk("step_ok",  int'(e.tag), 16'(step_ok),   16'(e.sok));
            chk("err_cnt",  int'(e.tag), err_cnt,        e.err);
            chk("stall",    int'(e.tag), 16'(stall),     16'(e.stl));
            chk("err_sat",  int'(e.tag), 16'(err_cnt_s), err_sat);
            chk("state_sat",int'(e.tag), 16'(state_s),   16'(e.st));
        end
    endtask

    initial begin
        logic [15:0] e;
        logic [2:0]  rp;
        rst = 1'b1;
        first_value = 3'b110;
        pat = 3'b000;

        // Reset, acquisition, lock, mismatch while locked, re-lock.
        // first_value is changed to 000 once rst drops to show it is ignored.
        add(1, 3'b110, 3'b000, S_SEEK, 0, 0, 0);
        add(1, 3'b110, 3'b000, S_SEEK, 0, 0, 0);
        add(0, 3'b000, 3'b110, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b110, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b110, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b101, S_TRK,  1, 0, 0);
        add(0, 3'b000, 3'b101, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b101, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b011, S_TRK,  1, 0, 0);
        add(0, 3'b000, 3'b011, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b011, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b110, S_TRK,  1, 0, 0);
        add(0, 3'b000, 3'b110, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b110, S_TRK,  0, 0, 0);
        add(0, 3'b000, 3'b101, S_LCK,  1, 0, 0);
        add(0, 3'b000, 3'b101, S_LCK,  0, 0, 0);
        add(0, 3'b000, 3'b101, S_LCK,  0, 0, 0);
        add(0, 3'b000, 3'b111, S_SEEK, 0, 1, 0);
        add(0, 3'b000, 3'b111, S_SEEK, 0, 1, 0);
        add(0, 3'b000, 3'b110, S_TRK,  0, 1, 0);
        add(0, 3'b000, 3'b101, S_TRK,  1, 1, 0);
        add(0, 3'b000, 3'b011, S_TRK,  1, 1, 0);
        add(0, 3'b000, 3'b110, S_TRK,  1, 1, 0);
        add(0, 3'b000, 3'b101, S_LCK,  1, 1, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].fv, tbl[i].pat, tbl[i].st, tbl[i].sok,
                  tbl[i].err, tbl[i].stl, i);
        end

        // Correct step arriving on the terminal idle count: step wins.
        for (int i = 0; i < 15; i++) apply(0, 3'b000, 3'b101, S_LCK, 0, 1, 0, 100 + i);
        apply(0, 3'b000, 3'b011, S_LCK, 1, 1, 0, 115);

        // Pattern frozen while locked: stall on the 16th idle cycle.
        for (int i = 0; i < 15; i++) apply(0, 3'b000, 3'b011, S_LCK, 0, 1, 0, 200 + i);
        apply(0, 3'b000, 3'b011, S_SEEK, 0, 1, 1, 215);

        // Mismatch in TRACK leaves err_cnt alone; relock keeps stall set.
        apply(0, 3'b000, 3'b110, S_TRK,  0, 1, 1, 300);
        apply(0, 3'b000, 3'b101, S_TRK,  1, 1, 1, 301);
        apply(0, 3'b000, 3'b111, S_SEEK, 0, 1, 1, 302);
        apply(0, 3'b000, 3'b110, S_TRK,  0, 1, 1, 303);
        apply(0, 3'b000, 3'b101, S_TRK,  1, 1, 1, 304);
        apply(0, 3'b000, 3'b011, S_TRK,  1, 1, 1, 305);
        apply(0, 3'b000, 3'b110, S_TRK,  1, 1, 1, 306);
        apply(0, 3'b000, 3'b101, S_LCK,  1, 1, 1, 307);

        // Repeated locked mismatches; the 2-bit instance saturates at 3.
        e = 16'd1;
        for (int k = 0; k < 3; k++) begin
            e = e + 16'd1;
            apply(0, 3'b000, 3'b111, S_SEEK, 0, e, 1, 400 + 10 * k);
            apply(0, 3'b000, 3'b110, S_TRK,  0, e, 1, 401 + 10 * k);
            apply(0, 3'b000, 3'b101, S_TRK,  1, e, 1, 402 + 10 * k);
            apply(0, 3'b000, 3'b011, S_TRK,  1, e, 1, 403 + 10 * k);
            apply(0, 3'b000, 3'b110, S_TRK,  1, e, 1, 404 + 10 * k);
            apply(0, 3'b000, 3'b101, S_LCK,  1, e, 1, 405 + 10 * k);
        end

        // Reset pulse in TRACK with a new seed 011.
        apply(0, 3'b000, 3'b111, S_SEEK, 0, 5, 1, 500);
        apply(0, 3'b000, 3'b110, S_TRK,  0, 5, 1, 501);
        apply(1, 3'b011, 3'b101, S_SEEK, 0, 0, 0, 502);
        apply(0, 3'b000, 3'b011, S_TRK,  0, 0, 0, 503);
        apply(0, 3'b000, 3'b110, S_TRK,  1, 0, 0, 504);
        apply(0, 3'b000, 3'b101, S_TRK,  1, 0, 0, 505);
        apply(0, 3'b000, 3'b011, S_TRK,  1, 0, 0, 506);
        apply(0, 3'b000, 3'b110, S_LCK,  1, 0, 0, 507);

        // Degenerate seeds: absorbing BADSEED whatever the pattern does.
        apply(1, 3'b000, 3'b000, S_SEEK, 0, 0, 0, 600);
        for (int i = 0; i < 100; i++) begin
            rp = 3'($urandom_range(7, 0));
            apply(0, 3'b000, rp, S_BAD, 0, 0, 0, 601 + i);
        end
        apply(1, 3'b111, 3'b111, S_SEEK, 0, 0, 0, 700);
        for (int i = 0; i < 30; i++) begin
            rp = 3'($urandom_range(7, 0));
            apply(0, 3'b000, rp, S_BAD, 0, 0, 0, 701 + i);
        end

        // Reset with a good seed leaves BADSEED.
        apply(1, 3'b110, 3'b000, S_SEEK, 0, 0, 0, 800);
        apply(0, 3'b000, 3'b110, S_TRK,  0, 0, 0, 801);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
